dmem_resp: RTL
==============

// Module: dmem_resp
// PURPOSE
//  Data-memory responder: the target end of the EX-stage memory request
//  (ena/rw/addr/data). Owns a word-organised data RAM and serves one request
//  at a time with configurable wait states. Stalls the pipeline while busy,
//  then returns load data with its GPR write-back address.
// PARAMETERS
//  DEPTH        1024  RAM size in 32-bit words; power of two; AW = $clog2(DEPTH)
//  WAIT_CYCLES  1     extra wait states per access, 0..15
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  mem_ena_i      in   1   request valid; held by the pipeline while stall_o=1
//  mem_rw_i       in   1   0 = read (MEM_READ), 1 = write (MEM_WRITE)
//  mem_addr_i     in   32  byte address
//  mem_data_i     in   32  write data
//  gprs_waddr_i   in   5   destination GPR of a load
//  stall_o        out  1   freeze the upstream pipeline
//  resp_valid_o   out  1   one-cycle pulse: access completed
//  resp_err_o     out  1   qualifies resp_valid_o: access rejected
//  rdata_o        out  32  load data; registered, holds until the next read
//  gprs_we_o      out  1   load write-back enable, one-cycle pulse
//  gprs_waddr_o   out  5   latched load destination
// BEHAVIOUR
//  Reset: state=IDLE, wait counter=0.
//  - All outputs are 0.
//  - The latched request is cleared.
//  - RAM contents are not reset.
//  FSM IDLE -> WAIT -> RESP -> IDLE:
//  - IDLE, mem_ena_i=1: latch rw/addr/data/waddr, counter=WAIT_CYCLES.
//    Go to WAIT, or directly to RESP when WAIT_CYCLES=0.
//  - WAIT: decrement the counter. When it reaches 0, go to RESP.
//  - The RAM access happens on the clock edge that enters RESP.
//    A write updates the RAM. A read loads rdata_o.
//  - RESP: lasts one cycle. resp_valid_o=1. For a read with no error,
//    gprs_we_o=1. mem_ena_i is ignored here because it is the same request.
//    Next state is IDLE.
//  stall_o (combinational):
//  - 1 when (IDLE and mem_ena_i) or WAIT. 0 in RESP.
//  - The pipeline therefore advances on the RESP cycle.
//  Latency: request seen in cycle T -> resp_valid_o in cycle T+1+WAIT_CYCLES.
//  Throughput: one access per 2+WAIT_CYCLES cycles.
//  Addressing:
//  - Word index = addr[AW+1:2].
//  - If addr[31:AW+2] != 0 the address is out of range:
//    - resp_err_o=1 in RESP;
//    - a write is dropped;
//    - a read returns 0 and gprs_we_o=0.
//  Reset mid-operation: the FSM returns to IDLE and any pending write is
//  discarded. Only accesses that have entered RESP have taken effect.
//  gprs_waddr_o: holds the last latched value. It is meaningful only while
//  gprs_we_o=1.
// CONFIGURATION
//  DMEM_MISALIGN_CHK_EN
//  - Defined: addr[1:0] != 0 is treated like an out-of-range address
//    (resp_err_o=1, write dropped, read returns 0, gprs_we_o=0).
//  - Undefined: addr[1:0] is ignored and the access is word-aligned down.
// TESTING
//  1. WAIT_CYCLES=1. Write 0xDEADBEEF to 0x10, then read 0x10 with x7.
//     -> rdata_o=0xDEADBEEF, gprs_we_o pulse, gprs_waddr_o=7.
//  2. Check latency and stall: request in cycle T.
//     -> stall_o=1 for T..T+1, resp_valid_o only at T+2.
//     Repeat with WAIT_CYCLES=0 and 3 (responses at T+1, T+4).
//  3. Read address 0x0000_1000 with DEPTH=1024.
//     -> resp_err_o=1, rdata_o=0, gprs_we_o=0.
//     A write there leaves word 0 unchanged.
//  4. Write 0x1 to 0x22.
//     -> with DMEM_MISALIGN_CHK_EN: resp_err_o=1, word 8 unchanged.
//     -> without it: word 8 = 0x1, no error.
//  5. Assert rst_n=0 in a WAIT cycle of a write to 0x40, then read 0x40.
//     -> old value returned; all outputs 0 during reset.
//  6. Issue back-to-back reads 0x0, 0x4, 0x8 with mem_ena_i held high.
//     -> exactly three resp_valid_o pulses, in order.

Source files
------------

// File: rtl/dmem_resp.sv
// Data-memory responder: serves one EX-stage load/store at a time from a word RAM,
// stalling the pipeline through WAIT_CYCLES wait states. Option: DMEM_MISALIGN_CHK_EN.
module dmem_resp #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ena_i,
  input  logic        mem_rw_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [4:0]  gprs_waddr_i,
  output logic        stall_o,
  output logic        resp_valid_o,
  output logic        resp_err_o,
  output logic [31:0] rdata_o,
  output logic        gprs_we_o,
  output logic [4:0]  gprs_waddr_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

`ifdef DMEM_MISALIGN_CHK_EN
  localparam bit CHK_MISALIGN = 1'b1;
`else
  localparam bit CHK_MISALIGN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        req_rw;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        resp_err_q;
  logic        latch;
  logic        access;
  logic        acc_rw;
  logic [31:0] acc_addr;
  logic [31:0] acc_data;
  logic [31:0] acc_high;
  logic        acc_err;
  logic [AW-1:0] acc_idx;

  logic [31:0] ram [DEPTH];

  // With zero wait states the access happens straight from IDLE, so the
  // live request is used instead of the (not yet) latched copy.
  assign latch    = (state == IDLE) && mem_ena_i;
  assign acc_rw   = (state == IDLE) ? mem_rw_i   : req_rw;
  assign acc_addr = (state == IDLE) ? mem_addr_i : req_addr;
  assign acc_data = (state == IDLE) ? mem_data_i : req_data;
  assign acc_high = acc_addr >> (AW + 2);
  assign acc_idx  = acc_addr[AW+1:2];
  assign acc_err  = (acc_high != 32'd0) || (CHK_MISALIGN && (acc_addr[1:0] != 2'b00));

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    access     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_ena_i) begin
          cnt_next = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            access     = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_next = RESP;
          access     = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      req_rw       <= 1'b0;
      req_addr     <= 32'd0;
      req_data     <= 32'd0;
      gprs_waddr_o <= 5'd0;
      resp_err_q   <= 1'b0;
      rdata_o      <= 32'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (latch) begin
        req_rw       <= mem_rw_i;
        req_addr     <= mem_addr_i;
        req_data     <= mem_data_i;
        gprs_waddr_o <= gprs_waddr_i;
      end
      if (access) begin
        resp_err_q <= acc_err;
        if (!acc_rw)
          rdata_o <= acc_err ? 32'd0 : ram[acc_idx];
      end
    end
  end

  // RAM is never reset; rst_n gating keeps a write from landing while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && access && acc_rw && !acc_err)
      ram[acc_idx] <= acc_data;
  end

  assign stall_o      = rst_n && (latch || (state == WAIT));
  assign resp_valid_o = (state == RESP);
  assign resp_err_o   = (state == RESP) && resp_err_q;
  assign gprs_we_o    = (state == RESP) && !req_rw && !resp_err_q;

endmodule
